// File: rtl/frame_buf_pkg.sv
// Shared types and constants for the ping-pong frame buffer.
package frame_buf_pkg;

    typedef logic bank_sel_t;

    typedef enum logic {
        FILL   = 1'b0,
        LOCKED = 1'b1
    } wr_state_t;

    localparam int MAX_RD_LATENCY = 2;
    localparam int STAT_W         = 16;

endpackage

// File: rtl/bram_sdp.sv
// Simple dual-port block RAM: one write port, one registered read port.
module bram_sdp #(
    parameter int ADDR_W = 17,
    parameter int WIDTH  = 24
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  din,
    input  logic              re,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data_q
);

    (* ram_style = "block" *) logic [WIDTH-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= din;
        end
        if (re) begin
            rd_data_q <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/frame_buffer_pp.sv
// Double-buffered frame store; banks swap only at a reader frame start once the writer has a full frame.
// Define FRAME_BUF_STATS_EN to keep the frames_repeated counter; otherwise it is tied to zero.
module frame_buffer_pp
    import frame_buf_pkg::*;
#(
    parameter int LOGSIZE    = 16,
    parameter int WIDTH      = 24,
    parameter int RD_LATENCY = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [LOGSIZE-1:0] wr_addr,
    input  logic [WIDTH-1:0]   din,
    input  logic               wr_done,
    output logic               wr_ready,
    input  logic               re,
    input  logic [LOGSIZE-1:0] rd_addr,
    input  logic               rd_sync,
    output logic [WIDTH-1:0]   dout,
    output logic               rd_valid,
    output logic               front_sel,
    output logic [STAT_W-1:0]  frames_repeated
);

    wr_state_t        state_q, state_d;
    bank_sel_t        front_q, front_d;
    logic             swap;
    logic             mem_we;
    logic             rd_v1_q, rd_v1_d;
    logic [WIDTH-1:0] ram_rdata;

    always_comb begin
        state_d = state_q;
        front_d = front_q;
        swap    = rd_sync && ((state_q == LOCKED) || wr_done);
        if (swap) begin
            state_d = FILL;
            front_d = ~front_q;
        end else if ((state_q == FILL) && wr_done) begin
            state_d = LOCKED;
        end
        wr_ready = (state_q == FILL);
        mem_we   = we && (state_q == FILL);
        rd_v1_d  = re;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            front_q <= 1'b0;
            rd_v1_q <= 1'b0;
        end else begin
            state_q <= state_d;
            front_q <= front_d;
            rd_v1_q <= rd_v1_d;
        end
    end

    assign front_sel = front_q;

    // Writer always targets the back bank; bank is sampled with the address on the request cycle.
    bram_sdp #(
        .ADDR_W (LOGSIZE + 1),
        .WIDTH  (WIDTH)
    ) u_bram (
        .clk       (clk),
        .we        (mem_we),
        .wr_addr   ({~front_q, wr_addr}),
        .din       (din),
        .re        (re),
        .rd_addr   ({front_q, rd_addr}),
        .rd_data_q (ram_rdata)
    );

    if (RD_LATENCY == 1) begin : g_lat1
        // RAM output register is not reset, so mask it until the first read lands.
        logic seen_q, seen_d;
        always_comb seen_d = seen_q | rd_v1_q;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) seen_q <= 1'b0;
            else     seen_q <= seen_d;
        end
        assign dout     = (seen_q | rd_v1_q) ? ram_rdata : '0;
        assign rd_valid = rd_v1_q;
    end else if (RD_LATENCY == MAX_RD_LATENCY) begin : g_lat2
        logic             rd_v2_q, rd_v2_d;
        logic [WIDTH-1:0] dout_q, dout_d;
        always_comb begin
            rd_v2_d = rd_v1_q;
            dout_d  = rd_v1_q ? ram_rdata : dout_q;
        end
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_v2_q <= 1'b0;
                dout_q  <= '0;
            end else begin
                rd_v2_q <= rd_v2_d;
                dout_q  <= dout_d;
            end
        end
        assign dout     = dout_q;
        assign rd_valid = rd_v2_q;
    end else begin : g_bad_latency
        $error("frame_buffer_pp: RD_LATENCY must be 1 or 2");
    end

`ifdef FRAME_BUF_STATS_EN
    logic [STAT_W-1:0] rep_q, rep_d;
    always_comb begin
        rep_d = rep_q;
        if (rd_sync && !swap && (rep_q != {STAT_W{1'b1}})) begin
            rep_d = rep_q + 1'b1;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rep_q <= '0;
        else     rep_q <= rep_d;
    end
    assign frames_repeated = rep_q;
`else
    assign frames_repeated = '0;
`endif

endmodule

// File: tb/tb_frame_buffer_pp.sv
// Drives latency-1 and latency-2 instances in lockstep against a bank-level reference model.
module tb_frame_buffer_pp;

    localparam int LS = 6;
    localparam int W  = 24;
    localparam int N  = 1 << LS;

    logic          clk;
    logic          rst;
    logic          we;
    logic [LS-1:0] wr_addr;
    logic [W-1:0]  din;
    logic          wr_done;
    logic          re;
    logic [LS-1:0] rd_addr;
    logic          rd_sync;

    logic          wr_ready1, wr_ready2, rd_valid1, rd_valid2, front1, front2;
    logic [W-1:0]  dout1, dout2;
    logic [15:0]   frep1, frep2;

    frame_buffer_pp #(.LOGSIZE(LS), .WIDTH(W), .RD_LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .we(we), .wr_addr(wr_addr), .din(din),
        .wr_done(wr_done), .wr_ready(wr_ready1), .re(re), .rd_addr(rd_addr),
        .rd_sync(rd_sync), .dout(dout1), .rd_valid(rd_valid1),
        .front_sel(front1), .frames_repeated(frep1)
    );

    frame_buffer_pp #(.LOGSIZE(LS), .WIDTH(W), .RD_LATENCY(2)) u_dut2 (
        .clk(clk), .rst(rst), .we(we), .wr_addr(wr_addr), .din(din),
        .wr_done(wr_done), .wr_ready(wr_ready2), .re(re), .rd_addr(rd_addr),
        .rd_sync(rd_sync), .dout(dout2), .rd_valid(rd_valid2),
        .front_sel(front2), .frames_repeated(frep2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: two banks of words, which bank is displayed, whether a finished frame waits.
    logic [W-1:0] mem_m [2][N];
    bit           kn_m  [2][N];
    int           front_m;
    bit           locked_m;
    int           rep_m;
    bit           exp_v1, exp_v2, exp_k1, exp_k2, prev_re, prev_k;
    logic [W-1:0] exp_d1, exp_d2, prev_d;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int exp_rep();
`ifdef FRAME_BUF_STATS_EN
        return rep_m;
`else
        return 0;
`endif
    endfunction

    task automatic check_all();
        chk("rd_valid_l1", 32'(rd_valid1), 32'(exp_v1));
        chk("rd_valid_l2", 32'(rd_valid2), 32'(exp_v2));
        if (exp_k1) chk("dout_l1", 32'(dout1), 32'(exp_d1));
        if (exp_k2) chk("dout_l2", 32'(dout2), 32'(exp_d2));
        chk("front_sel_l1", 32'(front1), 32'(front_m));
        chk("front_sel_l2", 32'(front2), 32'(front_m));
        chk("wr_ready_l1", 32'(wr_ready1), 32'(!locked_m));
        chk("wr_ready_l2", 32'(wr_ready2), 32'(!locked_m));
        chk("frames_rep_l1", 32'(frep1), 32'(exp_rep()));
        chk("frames_rep_l2", 32'(frep2), 32'(exp_rep()));
    endtask

    task automatic model_reset();
        front_m  = 0;
        locked_m = 1'b0;
        rep_m    = 0;
        exp_v1 = 1'b0; exp_v2 = 1'b0; prev_re = 1'b0;
        exp_d1 = '0;   exp_d2 = '0;
        exp_k1 = 1'b1; exp_k2 = 1'b1;
    endtask

    // One clock edge: snapshot inputs, advance the model, compare everything.
    task automatic cyc();
        bit            s_we, s_done, s_re, s_sync, rk;
        logic [LS-1:0] s_wa, s_ra;
        logic [W-1:0]  s_din, rdat;
        s_we = we; s_done = wr_done; s_re = re; s_sync = rd_sync;
        s_wa = wr_addr; s_ra = rd_addr; s_din = din;
        rdat = mem_m[front_m][s_ra];
        rk   = kn_m[front_m][s_ra];
        @(posedge clk);
        #1;
        if (s_we && !locked_m) begin
            mem_m[1-front_m][s_wa] = s_din;
            kn_m[1-front_m][s_wa]  = 1'b1;
        end
        if (s_sync && (locked_m || s_done)) begin
            front_m  = 1 - front_m;
            locked_m = 1'b0;
        end else begin
            if (s_sync && rep_m < 65535) rep_m++;
            if (s_done) locked_m = 1'b1;
        end
        exp_v2 = prev_re;
        if (prev_re) begin exp_d2 = prev_d; exp_k2 = prev_k; end
        exp_v1 = s_re;
        if (s_re) begin exp_d1 = rdat; exp_k1 = rk; end
        prev_re = s_re; prev_d = rdat; prev_k = rk;
        check_all();
    endtask

    task automatic idle_inputs();
        we = 1'b0; wr_done = 1'b0; re = 1'b0; rd_sync = 1'b0;
        wr_addr = '0; rd_addr = '0; din = '0;
    endtask

    initial begin
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < N; a++) begin
                mem_m[b][a] = '0;
                kn_m[b][a]  = 1'b0;
            end
        idle_inputs();
        rst = 1'b1;
        model_reset();
        #12;
        rst = 1'b0;
        #1;
        chk("reset_front", 32'(front1), 32'd0);
        chk("reset_wr_ready", 32'(wr_ready2), 32'd1);
        chk("reset_dout_l1", 32'(dout1), 32'd0);
        chk("reset_dout_l2", 32'(dout2), 32'd0);
        repeat (2) cyc();

        // Fill, finish, blocked overwrite, swap, read back.
        we = 1'b1; wr_addr = 6'd5; din = 24'hABCDEF; cyc();
        we = 1'b0; wr_done = 1'b1; cyc();
        wr_done = 1'b0; we = 1'b1; din = 24'h123456; cyc();
        chk("locked_wr_ready", 32'(wr_ready1), 32'd0);
        we = 1'b0; rd_sync = 1'b1; cyc();
        chk("swap_front", 32'(front1), 32'd1);
        rd_sync = 1'b0; re = 1'b1; rd_addr = 6'd5; cyc();
        chk("read_l1_data", 32'(dout1), 32'hABCDEF);
        chk("read_l2_not_yet", 32'(rd_valid2), 32'd0);
        re = 1'b0; cyc();
        chk("read_l2_data", 32'(dout2), 32'hABCDEF);
        chk("read_l1_hold", 32'(dout1), 32'hABCDEF);

        // Frame starts with nothing finished: repeat the front bank.
        repeat (3) begin
            rd_sync = 1'b1; cyc();
            rd_sync = 1'b0; cyc();
        end
        chk("repeat_front", 32'(front2), 32'd1);

        // Finish and swap in the same cycle as a read.
        we = 1'b1; wr_addr = 6'd5; din = 24'h5A5A5A; cyc();
        we = 1'b0; wr_done = 1'b1; rd_sync = 1'b1; re = 1'b1; rd_addr = 6'd5; cyc();
        chk("swap_read_old", 32'(dout1), 32'hABCDEF);
        wr_done = 1'b0; rd_sync = 1'b0; cyc();
        chk("after_swap_new", 32'(dout1), 32'h5A5A5A);
        re = 1'b0; cyc();
        chk("after_swap_new_l2", 32'(dout2), 32'h5A5A5A);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            we      = ($urandom_range(1) == 1);
            wr_addr = LS'($urandom);
            din     = W'($urandom);
            wr_done = ($urandom_range(15) == 0);
            rd_sync = ($urandom_range(11) == 0);
            re      = ($urandom_range(1) == 1);
            rd_addr = LS'($urandom);
            cyc();
        end
        idle_inputs();
        cyc();

        // Reset while locked with a read in flight.
        for (int k = 0; k < 4 && front_m != 1; k++) begin
            wr_done = 1'b1; rd_sync = 1'b1; cyc();
        end
        rd_sync = 1'b0; wr_done = 1'b1; cyc();
        wr_done = 1'b0; re = 1'b1; rd_addr = 6'd5; cyc();
        re = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_rd_valid_l1", 32'(rd_valid1), 32'd0);
        chk("rst_rd_valid_l2", 32'(rd_valid2), 32'd0);
        chk("rst_front", 32'(front1), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready1), 32'd1);
        chk("rst_dout_l2", 32'(dout2), 32'd0);
        chk("rst_frames", 32'(frep1), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all();
        repeat (3) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_buffer_pp.md
Name: frame_buffer_pp

Overview:
- Parametrised ping-pong (double-buffered) frame store built on block RAM.
- Writer (camera/processing side) fills the back bank; reader (VGA/display side) reads the front bank.
- Banks swap atomically only at a reader frame boundary, and only when the writer has completed a full frame. This removes tearing.
- Successor to the single-bank frame BRAM. Adds bank swapping, write back-pressure, configurable read latency with a valid strobe, and reset.

Parameters:
- LOGSIZE, 16, log2 of words per bank; each bank holds 2^LOGSIZE words.
- WIDTH, 24, pixel word width in bits.
- RD_LATENCY, 1, read latency in cycles; legal values 1 or 2 (2 adds an output register). Any other value is an elaboration error.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- we  in  1  write strobe; honoured only when wr_ready=1.
- wr_addr  in  LOGSIZE  write address within the back bank.
- din  in  WIDTH  write data.
- wr_done  in  1  single-cycle pulse: back bank frame complete.
- wr_ready  out  1  1 = back bank writable; 0 = frame complete, locked until swap.
- re  in  1  read strobe.
- rd_addr  in  LOGSIZE  read address within the front bank.
- rd_sync  in  1  single-cycle pulse at reader frame start (e.g. vsync).
- dout  out  WIDTH  read data.
- rd_valid  out  1  high exactly RD_LATENCY cycles after an accepted re.
- front_sel  out  1  index of the current front bank.
- frames_repeated  out  16  count of rd_sync events with no complete frame available.

Behaviour:
- Storage is 2*2^LOGSIZE words. Physical address = {bank, addr}. Back bank = ~front_sel.
- Memory contents are not reset. Addresses are power-of-two, so there is no out-of-range case.
- Reset (async): front_sel=0, wr_ready=1, wr_pend=0, dout=0, rd_valid=0, read pipeline cleared, frames_repeated=0.
- Reset mid-frame discards frame state; the back bank becomes writable immediately.
- Writer FSM has two states:
  - FILL: wr_ready=1; we writes din to back bank. wr_done -> LOCKED (wr_pend=1).
  - LOCKED: wr_ready=0; we is ignored (no memory write); wr_done is ignored. A swap -> FILL.
- A write and wr_done in the same cycle: the write is committed, then the FSM enters LOCKED.
- Swap rule: at the edge where rd_sync=1 and (state=LOCKED or wr_done=1):
  - front_sel toggles and the FSM goes to FILL.
  - The next cycle has wr_ready=1, with the new back bank = the old front bank.
- rd_sync without a complete frame: no swap; the reader redisplays the same front bank; frames_repeated increments.
- Read path:
  - The bank is sampled together with rd_addr on the re cycle. A read issued in a swap cycle returns old-front-bank data.
  - RD_LATENCY=1: dout and rd_valid update at edge N+1.
  - RD_LATENCY=2: dout and rd_valid update at edge N+2.
  - dout holds its value when no read is in flight.
- Reads and writes never target the same bank, so there is no read-during-write hazard.
- frames_repeated saturates at 16'hFFFF.

Optional Feature:
- Macro FRAME_BUF_STATS_EN.
- Defined: frames_repeated behaves as specified above.
- Undefined: the counter logic is removed and frames_repeated is tied to 0. The port is always present.

Decomposition:
- Package frame_buf_pkg holds:
  - bank select type (1-bit);
  - writer FSM state enum (FILL, LOCKED);
  - constant MAX_RD_LATENCY=2;
  - counter width constant STAT_W=16.
- Sub-module bram_sdp: simple dual-port RAM, parameters LOGSIZE+1 and WIDTH, one read cycle, ram_style block.
- The top level adds bank muxing, the FSM, and the optional output register and valid pipeline.

Test Plan:
- Reset then idle -> front_sel=0, wr_ready=1, rd_valid=0, dout=0, frames_repeated=0.
- Write addr 5 = 24'hABCDEF, pulse wr_done, pulse rd_sync, then re addr 5 -> front_sel=1; dout=24'hABCDEF with rd_valid after exactly RD_LATENCY cycles (run with 1 and 2).
- After wr_done, attempt write addr 5 = 24'h123456 before rd_sync -> wr_ready=0; after swap, front bank addr 5 still reads 24'hABCDEF.
- Three rd_sync pulses with no wr_done -> no swap, frames_repeated=3 (0 with macro undefined).
- wr_done and rd_sync in the same cycle, plus re issued that cycle -> swap occurs; that read returns old-front data; the next read returns new data.
- Assert rst while LOCKED with a read in flight -> rd_valid drops immediately; front_sel=0, wr_ready=1.
